// File: rtl/muldiv_unit_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// master drives operands and control; slave returns status and result.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [6:0]       Funct7;
  logic [2:0]       Funct3;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Result;
  logic             illegal;

  modport master (
    output start, Funct7, Funct3, A, B, flush,
    input  busy, done, Result, illegal
  );

  modport slave (
    input  start, Funct7, Funct3, A, B, flush,
    output busy, done, Result, illegal
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV M-extension unit: one operand bit per cycle, shift-add multiply and
// restoring divide on magnitudes, sign applied when the result is written.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic           clk,
  input logic           reset,
  muldiv_unit_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic               byp_q, byp_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ill_q, ill_d;

  // Entry decode
  logic             a_sgn, b_sgn, neg_a, neg_b, div_zero, div_ovf;
  logic [WIDTH-1:0] mag_a, mag_b, byp_res;

  always_comb begin
    a_sgn = (bus.Funct3 == 3'b000) || (bus.Funct3 == 3'b001) || (bus.Funct3 == 3'b010) ||
            (bus.Funct3 == 3'b100) || (bus.Funct3 == 3'b110);
    b_sgn = a_sgn && (bus.Funct3 != 3'b010);
    neg_a = a_sgn & bus.A[WIDTH-1];
    neg_b = b_sgn & bus.B[WIDTH-1];
    mag_a = neg_a ? -bus.A : bus.A;
    mag_b = neg_b ? -bus.B : bus.B;
    div_zero = bus.Funct3[2] && (bus.B == '0);
    div_ovf  = bus.Funct3[2] && !bus.Funct3[0] && (bus.A == MinVal) && (bus.B == '1);
    byp_res  = '0;
    if (div_zero) begin
      byp_res = bus.Funct3[1] ? bus.A : '1;
    end else if (div_ovf) begin
      byp_res = bus.Funct3[1] ? '0 : bus.A;
    end
  end

  // One iteration step and the signed final result
  logic [WIDTH:0]     msum, rtrial, rdiff;
  logic               qbit;
  logic [WIDTH-1:0]   rnew, quo_mag, rem_mag, quo, rem;
  logic [2*WIDTH-1:0] step, prod;
  logic [WIDTH-1:0]   fin_res;

  always_comb begin
    msum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? a_q : '0)};
    // Remainder shifted left with the next dividend bit; W+1 bits so the carry is kept
    rtrial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rdiff  = rtrial - {1'b0, b_q};
    qbit   = !rdiff[WIDTH];
    rnew   = qbit ? rdiff[WIDTH-1:0] : rtrial[WIDTH-1:0];
    if (op_q[2]) begin
      step = {rnew, acc_q[WIDTH-2:0], qbit};
    end else begin
      step = {msum, acc_q[WIDTH-1:1]};
    end
    prod    = neg_q ? -step : step;
    quo_mag = step[WIDTH-1:0];
    rem_mag = step[2*WIDTH-1:WIDTH];
    quo     = neg_q ? -quo_mag : quo_mag;
    rem     = neg_q ? -rem_mag : rem_mag;
    unique case (op_q)
      3'b000:                 fin_res = prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fin_res = prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fin_res = quo;
      default:                fin_res = rem;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    byp_d   = byp_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ill_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.flush) begin
          if (bus.Funct7 == 7'b0000001) begin
            state_d = StBusy;
            busy_d  = 1'b1;
            op_d    = bus.Funct3;
            cnt_d   = '0;
            a_d     = mag_a;
            b_d     = mag_b;
            neg_d   = (bus.Funct3[2] && bus.Funct3[1]) ? neg_a : (neg_a ^ neg_b);
            byp_d   = div_zero || div_ovf;
            if (div_zero || div_ovf) begin
              acc_d = {{WIDTH{1'b0}}, byp_res};
            end else begin
              acc_d = {{WIDTH{1'b0}}, (bus.Funct3[2] ? mag_a : mag_b)};
            end
          end else begin
            ill_d = 1'b1;
          end
        end
      end
      StBusy: begin
        if (bus.flush) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else if (byp_q) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          res_d   = acc_q[WIDTH-1:0];
        end else begin
          acc_d = step;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            res_d   = fin_res;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      byp_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      byp_q   <= byp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.Result  = res_q;
  assign bus.illegal = ill_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops
// compared against a 64-bit arithmetic reference model.
module tb_muldiv_unit;

  localparam int unsigned W = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  muldiv_unit_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sb, sbu, p;
    logic [63:0]        pu;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    sbu = {32'b0, b};
    pu  = {32'b0, a} * {32'b0, b};
    case (f3)
      3'd0: begin p = sa * sb;  return p[31:0];  end
      3'd1: begin p = sa * sb;  return p[63:32]; end
      3'd2: begin p = sa * sbu; return p[63:32]; end
      3'd3: return pu[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb;
        return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_bypass(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
    return f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Issue one legal op and check latency, busy length, Result stability and value
  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    int          cyc, busy_cnt, lat;
    logic [31:0] prev_res;
    logic        res_moved;
    lat = is_bypass(f3, a, b) ? 2 : W + 1;
    @(negedge clk);
    prev_res   = bus.Result;
    bus.start  = 1'b1;
    bus.Funct7 = 7'b0000001;
    bus.Funct3 = f3;
    bus.A      = a;
    bus.B      = b;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    busy_cnt = 0;
    res_moved = 1'b0;
    while (bus.done !== 1'b1 && cyc < 3 * W) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.Result !== prev_res) res_moved = 1'b1;
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "/done_cycle"}, cyc, lat);
    check_eq({tag, "/busy_cycles"}, busy_cnt, lat - 1);
    check_eq({tag, "/result_stable"}, {31'b0, res_moved}, 32'd0);
    check_eq({tag, "/result"}, bus.Result, exp);
    @(negedge clk);
    check_eq({tag, "/done_pulse"}, {31'b0, bus.done}, 32'd0);
    check_eq({tag, "/result_hold"}, bus.Result, exp);
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) n++;
    end
  endtask

  initial begin
    logic [31:0] a, b, prev;
    logic [2:0]  f3;
    int          nd;
    logic [31:0] corners [6];
    corners[0] = 32'h0;
    corners[1] = 32'hFFFF_FFFF;
    corners[2] = 32'h8000_0000;
    corners[3] = 32'h7FFF_FFFF;
    corners[4] = 32'h1;
    corners[5] = 32'h2;

    bus.start  = 1'b0;
    bus.Funct7 = 7'b0000001;
    bus.Funct3 = 3'b000;
    bus.A      = '0;
    bus.B      = '0;
    bus.flush  = 1'b0;

    #2 reset = 1'b1;
    #1;
    check_eq("reset/busy", {31'b0, bus.busy}, 32'd0);
    check_eq("reset/done", {31'b0, bus.done}, 32'd0);
    check_eq("reset/illegal", {31'b0, bus.illegal}, 32'd0);
    check_eq("reset/result", bus.Result, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    do_op("mul_7xm3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    do_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    do_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    do_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
    do_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    do_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    do_op("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14);
    do_op("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2);
    do_op("divu_by0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
    do_op("rem_by0", 3'd6, 32'd5, 32'd0, 32'd5);
    do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    do_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    for (int i = 0; i < 32; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 2) == 0) b = b & 32'hFF;
      do_op($sformatf("rand%0d_f%0d", i, f3), f3, a, b, ref_op(f3, a, b));
    end

    // Repeated start during BUSY is ignored
    do_op("pre_ign", 3'd0, 32'd6, 32'd7, 32'd42);
    @(negedge clk);
    bus.start = 1'b1; bus.Funct3 = 3'd0; bus.A = 32'd3; bus.B = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.Funct3 = 3'd5; bus.A = 32'd100; bus.B = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    count_dones(3 * W, nd);
    check_eq("ignore/done_count", nd, 32'd1);
    check_eq("ignore/result", bus.Result, 32'd15);

    // Flush in cycle 10 aborts with Result untouched
    prev = bus.Result;
    @(negedge clk);
    bus.start = 1'b1; bus.Funct3 = 3'd0; bus.A = 32'd9; bus.B = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check_eq("flush/busy", {31'b0, bus.busy}, 32'd0);
    count_dones(2 * W, nd);
    check_eq("flush/no_done", nd, 32'd0);
    check_eq("flush/result", bus.Result, prev);

    // Flush together with start in IDLE
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    check_eq("flush_start/busy", {31'b0, bus.busy}, 32'd0);
    check_eq("flush_start/illegal", {31'b0, bus.illegal}, 32'd0);
    count_dones(W + 4, nd);
    check_eq("flush_start/no_done", nd, 32'd0);

    // Wrong Funct7
    @(negedge clk);
    bus.start = 1'b1; bus.Funct7 = 7'b0000000;
    @(negedge clk);
    bus.start = 1'b0; bus.Funct7 = 7'b0000001;
    check_eq("illegal/pulse", {31'b0, bus.illegal}, 32'd1);
    check_eq("illegal/busy", {31'b0, bus.busy}, 32'd0);
    @(negedge clk);
    check_eq("illegal/one_cycle", {31'b0, bus.illegal}, 32'd0);
    count_dones(W + 4, nd);
    check_eq("illegal/no_done", nd, 32'd0);

    // Asynchronous reset mid-operation
    @(negedge clk);
    bus.start = 1'b1; bus.Funct3 = 3'd0; bus.A = 32'd7; bus.B = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("midreset/busy", {31'b0, bus.busy}, 32'd0);
    check_eq("midreset/done", {31'b0, bus.done}, 32'd0);
    check_eq("midreset/illegal", {31'b0, bus.illegal}, 32'd0);
    check_eq("midreset/result", bus.Result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    count_dones(2 * W, nd);
    check_eq("midreset/no_done", nd, 32'd0);
    do_op("post_reset", 3'd0, 32'd7, 32'd3, 32'd21);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand/result width in bits (even, >= 8).
REQ-002 SHALL have clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have reset  input  1  asynchronous, active-high reset; one clock domain only.
REQ-004 SHALL have start  input  1  request to begin an operation; sampled on the clk edge.
REQ-005 SHALL have Funct7  input  7  instruction bits 31:25; value 7'b0000001 marks an M-extension op.
REQ-006 SHALL have Funct3  input  3  instruction bits 14:12; selects the operation.
REQ-007 SHALL have A, B  input  WIDTH each  rs1 and rs2 operands.
REQ-008 SHALL have flush  input  1  pipeline flush; aborts any operation in progress.
REQ-009 SHALL have busy  output  1  high while an accepted operation is iterating.
REQ-010 SHALL have done  output  1  one-cycle pulse marking Result valid.
REQ-011 SHALL have Result  output  WIDTH  registered result.
REQ-012 SHALL have illegal  output  1  one-cycle pulse when start is seen with Funct7 != 7'b0000001.

Function
REQ-013 SHALL decode Funct3 as: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-014 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-015 IDLE with start=1, Funct7=0000001 and flush=0: latch Funct3, the operand magnitudes and the result sign, clear the iteration counter, and go to BUSY.
REQ-016 IDLE with start=1 and a wrong Funct7: stay in IDLE and pulse illegal for one cycle; the operation is not accepted.
REQ-017 start SHALL be ignored in BUSY and in DONE; there is no queueing.
REQ-018 BUSY SHALL run exactly WIDTH iterations: shift-add for multiply and restoring subtract-shift for divide, one operand bit per cycle, then go to DONE.
REQ-019 Timing: start sampled at edge 0 -> busy=1 during cycles 1..WIDTH -> done=1 and Result valid in cycle WIDTH+1 -> IDLE in cycle WIDTH+2.
REQ-020 Divide by zero: bypass iteration; BUSY lasts 1 cycle and done follows in cycle 2; DIV/DIVU give all ones, REM/REMU give A.
REQ-021 Signed overflow (DIV/REM with A = -2^(WIDTH-1) and B = -1): same 1-cycle bypass; DIV gives A, REM gives 0.
REQ-022 Signed handling: MUL/MULH/DIV/REM treat A and B as signed, MULHSU treats A signed and B unsigned, MULHU/DIVU/REMU treat both unsigned; iterate on magnitudes and apply the negation on entry to DONE.
REQ-023 Result width: MUL gives the low WIDTH bits of the 2*WIDTH product; MULH/MULHSU/MULHU give the high WIDTH bits.
REQ-024 The remainder sign SHALL follow the dividend, and the quotient SHALL truncate toward zero.
REQ-025 Result SHALL hold its value after DONE until the next done pulse; it SHALL NOT change during BUSY.
REQ-026 flush=1 in BUSY or DONE: go to IDLE on the next edge, force busy=0, suppress done, and leave Result unchanged.
REQ-027 flush=1 together with start in IDLE: flush wins and nothing is accepted.
REQ-028 busy, done and illegal SHALL be registered outputs, free of combinational paths from the inputs.

Reset
REQ-029 reset=1 SHALL act immediately, without waiting for clk: state=IDLE, busy=0, done=0, illegal=0, Result=0, counter=0, operand registers=0.
REQ-030 Reset asserted mid-operation SHALL discard the operation with no done pulse; the first start after release is accepted normally.

Verification
REQ-031 MUL with A=7, B=0xFFFFFFFD (WIDTH=32) -> Result=0xFFFFFFEB, done in cycle 33, busy high for exactly 32 cycles.
REQ-032 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-033 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-034 DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, with done in cycle 2; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM of the same operands -> 0, with done in cycle 2.
REQ-035 Abort and ignore cases: flush in cycle 10 of a MUL -> busy=0 next cycle, no done, Result keeps its prior value; reset in cycle 10 -> all outputs 0 immediately.
REQ-036 Funct7=0000000 with start -> illegal pulses once, busy stays 0; start repeated during BUSY -> ignored, and exactly one done occurs.
